// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore-style control FSM for the multicycle ARM-subset core.
// Sequences fetch/decode/execute/memory/writeback on a shared memory and ALU,
// owns the NZCV flag register and evaluates conditional execution from it.
module multicycle_controller #(
    parameter int ALUC_W      = 2,
    parameter int MEM_WAIT_EN = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        Cond,
    input  logic [1:0]        Op,
    input  logic [5:0]        Func,
    input  logic [3:0]        Rd,
    input  logic [3:0]        ALUFlags,
    input  logic              mem_ready,
    output logic              PCWrite,
    output logic              AdrSrc,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic [1:0]        ResultSrc,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic              RegWrite,
    output logic [ALUC_W-1:0] ALUControl,
    output logic [3:0]        Flags,
    output logic [3:0]        state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    // EOR and MOV only exist when the ALU control bus is wide enough to name them.
    localparam bit EXT_OPS = (ALUC_W >= 3);

    // Zero-extend or truncate a 3-bit ALU operation code to the configured bus width.
    function automatic logic [ALUC_W-1:0] alu_code(input logic [2:0] code);
        logic [ALUC_W+2:0] wide_v;
        wide_v = {{ALUC_W{1'b0}}, code};
        return wide_v[ALUC_W-1:0];
    endfunction

    // ARM condition-code evaluation against the stored NZCV register.
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n_v, z_v, c_v, v_v;
        logic res_v;
        {n_v, z_v, c_v, v_v} = nzcv;
        case (cond)
            4'b0000: res_v = z_v;
            4'b0001: res_v = ~z_v;
            4'b0010: res_v = c_v;
            4'b0011: res_v = ~c_v;
            4'b0100: res_v = n_v;
            4'b0101: res_v = ~n_v;
            4'b0110: res_v = v_v;
            4'b0111: res_v = ~v_v;
            4'b1000: res_v = c_v & ~z_v;
            4'b1001: res_v = ~c_v | z_v;
            4'b1010: res_v = (n_v == v_v);
            4'b1011: res_v = (n_v != v_v);
            4'b1100: res_v = ~z_v & (n_v == v_v);
            4'b1101: res_v = z_v | (n_v != v_v);
            4'b1110: res_v = 1'b1;
            default: res_v = 1'b0;
        endcase
        return res_v;
    endfunction

    state_t            state_r;
    state_t            next_state_s;
    logic [3:0]        flags_r;
    logic              cond_ex_s;
    logic              mem_ok_s;
    logic [ALUC_W-1:0] alu_cmd_s;
    logic              cmd_ok_s;
    logic              cmd_cmp_s;
    logic              flag_we_s;
    logic              pc_write_s;
    logic              mem_write_s;
    logic              ir_write_s;
    logic              reg_write_s;
    logic              adr_src_s;
    logic [1:0]        result_src_s;
    logic              alu_src_a_s;
    logic [1:0]        alu_src_b_s;
    logic [ALUC_W-1:0] alu_control_s;

    assign cond_ex_s = cond_check(Cond, flags_r);
    assign mem_ok_s  = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;

    // Decode the data-processing cmd field into an ALU op, a supported flag and CMP detection.
    always_comb begin
        alu_cmd_s = alu_code(3'd0);
        cmd_ok_s  = 1'b1;
        cmd_cmp_s = 1'b0;
        case (Func[4:1])
            4'b0100: alu_cmd_s = alu_code(3'd0);
            4'b0010: alu_cmd_s = alu_code(3'd1);
            4'b0000: alu_cmd_s = alu_code(3'd2);
            4'b1100: alu_cmd_s = alu_code(3'd3);
            4'b1010: begin
                alu_cmd_s = alu_code(3'd1);
                cmd_cmp_s = 1'b1;
            end
            4'b0001: begin
                if (EXT_OPS) begin
                    alu_cmd_s = alu_code(3'd4);
                end else begin
                    cmd_ok_s = 1'b0;
                end
            end
            4'b1101: begin
                if (EXT_OPS) begin
                    alu_cmd_s = alu_code(3'd5);
                end else begin
                    cmd_ok_s = 1'b0;
                end
            end
            default: cmd_ok_s = 1'b0;
        endcase
    end

    // Flags are captured at the end of an executed, supported data-processing op that sets them.
    always_comb begin
        if ((state_r == EXECR) || (state_r == EXECI)) begin
            flag_we_s = cond_ex_s & cmd_ok_s & (Func[0] | cmd_cmp_s);
        end else begin
            flag_we_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // NZCV register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= 4'b0000;
        end else if (flag_we_s) begin
            flags_r <= ALUFlags;
        end else begin
            flags_r <= flags_r;
        end
    end

    // Next-state and per-state control decode; every output starts from its idle value.
    always_comb begin
        next_state_s  = FETCH;
        pc_write_s    = 1'b0;
        mem_write_s   = 1'b0;
        ir_write_s    = 1'b0;
        reg_write_s   = 1'b0;
        adr_src_s     = 1'b0;
        result_src_s  = 2'b00;
        alu_src_a_s   = 1'b0;
        alu_src_b_s   = 2'b00;
        alu_control_s = alu_code(3'd0);
        case (state_r)
            FETCH: begin
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = mem_ok_s;
                pc_write_s   = mem_ok_s;
                next_state_s = mem_ok_s ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = 2'b10;
                if (!cond_ex_s || (Op == 2'b11)) begin
                    next_state_s = FETCH;
                end else if (Op == 2'b00) begin
                    next_state_s = Func[5] ? EXECI : EXECR;
                end else if (Op == 2'b01) begin
                    next_state_s = MEMADR;
                end else begin
                    next_state_s = BRANCH;
                end
            end
            EXECR, EXECI: begin
                alu_src_a_s   = 1'b1;
                alu_src_b_s   = (state_r == EXECI) ? 2'b01 : 2'b00;
                alu_control_s = alu_cmd_s;
                next_state_s  = (cmd_ok_s && !cmd_cmp_s) ? ALUWB : FETCH;
            end
            ALUWB: begin
                result_src_s = 2'b00;
                reg_write_s  = (Rd != 4'd15);
                pc_write_s   = (Rd == 4'd15);
                next_state_s = FETCH;
            end
            MEMADR: begin
                alu_src_a_s   = 1'b1;
                alu_src_b_s   = 2'b01;
                alu_control_s = Func[3] ? alu_code(3'd0) : alu_code(3'd1);
                next_state_s  = Func[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src_s    = 1'b1;
                next_state_s = mem_ok_s ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = (Rd != 4'd15);
                pc_write_s   = (Rd == 4'd15);
                next_state_s = FETCH;
            end
            MEMWRITE: begin
                adr_src_s    = 1'b1;
                mem_write_s  = 1'b1;
                next_state_s = mem_ok_s ? FETCH : MEMWRITE;
            end
            BRANCH: begin
                alu_src_a_s  = 1'b0;
                alu_src_b_s  = 2'b01;
                result_src_s = 2'b10;
                pc_write_s   = 1'b1;
                next_state_s = FETCH;
            end
            default: next_state_s = FETCH;
        endcase
    end

    // Write enables are held off combinationally while reset is asserted.
    assign PCWrite    = pc_write_s  & rst_n;
    assign IRWrite    = ir_write_s  & rst_n;
    assign RegWrite   = reg_write_s & rst_n;
    assign MemWrite   = mem_write_s & rst_n;
    assign AdrSrc     = adr_src_s;
    assign ResultSrc  = result_src_s;
    assign ALUSrcA    = alu_src_a_s;
    assign ALUSrcB    = alu_src_b_s;
    assign ALUControl = alu_control_s;
    assign ImmSrc     = Op;
    assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
    assign Flags      = flags_r;
    assign state_dbg  = state_r;

endmodule
